// File: rtl/period_meter.sv
// period_meter: measures period and high time of an asynchronous square wave in
// i_clock cycles and publishes each coherent (period, high) pair with a valid strobe.
module period_meter #(
  parameter int CNT_WIDTH = 20,
  parameter int TIMEOUT   = 1000000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_signal,
  output logic [CNT_WIDTH-1:0] o_period,
  output logic [CNT_WIDTH-1:0] o_high,
  output logic                 o_valid,
  output logic                 o_timeout
);

  localparam logic [CNT_WIDTH-1:0] LP_TIMEOUT = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] LP_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_s1;
  logic                 r_s2;
  logic                 r_s3;
  logic [1:0]           r_fill;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_hi_shadow;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic [CNT_WIDTH-1:0] w_hi_next;
  logic [CNT_WIDTH-1:0] w_period_next;
  logic [CNT_WIDTH-1:0] w_high_next;
  logic                 w_valid_next;
  logic                 w_timeout_next;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_cnt_sat;
  logic                 w_fill_done;

  assign w_rise      = r_s2 & ~r_s3;
  assign w_fall      = ~r_s2 & r_s3;
  assign w_cnt_sat   = (r_cnt >= LP_TIMEOUT);
  // The reset-zeroed synchronizer reads low before it has sampled the input;
  // IDLE only trusts s2 once the chain has been refilled.
  assign w_fill_done = (r_fill == 2'd3);

  // Synchronizer chain and post-reset fill tracker.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_fill <= 2'd0;
    end else begin
      r_s1 <= i_signal;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (!w_fill_done) begin
        r_fill <= r_fill + 2'd1;
      end
    end
  end

  // Cycle counter: restarts at 1 on each rise, saturates at the timeout.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_rise) begin
      w_cnt_next = LP_ONE;
    end else if (w_cnt_sat) begin
      w_cnt_next = LP_TIMEOUT;
    end else begin
      w_cnt_next = r_cnt + LP_ONE;
    end
  end

  // Next-state and result logic.
  always_comb begin
    w_state_next   = r_state;
    w_hi_next      = r_hi_shadow;
    w_period_next  = o_period;
    w_high_next    = o_high;
    w_valid_next   = 1'b0;
    w_timeout_next = o_timeout;
    case (r_state)
      ST_IDLE: begin
        if (w_fill_done && !r_s2) begin
          w_state_next = ST_ARMED;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (w_rise) begin
          w_state_next = ST_HIGH;
        end else begin
          w_state_next = ST_ARMED;
        end
      end
      ST_HIGH: begin
        if (w_cnt_sat) begin
          w_state_next   = ST_IDLE;
          w_timeout_next = 1'b1;
        end else if (w_fall) begin
          w_hi_next    = r_cnt;
          w_state_next = ST_LOW;
        end else begin
          w_state_next = ST_HIGH;
        end
      end
      ST_LOW: begin
        // A rise coinciding with saturation still completes the measurement.
        if (w_rise) begin
          w_period_next  = r_cnt;
          w_high_next    = r_hi_shadow;
          w_valid_next   = 1'b1;
          w_timeout_next = 1'b0;
          w_state_next   = ST_HIGH;
        end else if (w_cnt_sat) begin
          w_state_next   = ST_IDLE;
          w_timeout_next = 1'b1;
        end else begin
          w_state_next = ST_LOW;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CNT_WIDTH{1'b0}};
      r_hi_shadow <= {CNT_WIDTH{1'b0}};
      o_period    <= {CNT_WIDTH{1'b0}};
      o_high      <= {CNT_WIDTH{1'b0}};
      o_valid     <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_hi_shadow <= w_hi_next;
      o_period    <= w_period_next;
      o_high      <= w_high_next;
      o_valid     <= w_valid_next;
      o_timeout   <= w_timeout_next;
    end
  end

endmodule
